lz77_dec_sequencer: RTL and testbench
=====================================

Name: lz77_dec_sequencer

Overview:
Controller that sequences the LZ77_Decoder datapath.
- Accepts LZ77 code words (pos, len, char) from an upstream valid/ready stream and buffers them in a small FIFO.
- Issues each code word to the decoder and holds it stable for exactly the decoder's output length.
- Forwards decoded characters as a registered output stream, detects the '$' (8'h24) terminator, and waits for decoder finish.
- A watchdog flags a stalled decoder.

Parameters:
FIFO_DEPTH, 4, code-word buffer entries (power of 2, ≥2)
TIMEOUT, 16, max cycles tolerated waiting on dec_encode low or dec_finish high

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
cw_valid  in  1  upstream code word valid
cw_ready  out  1  FIFO not full
cw_pos  in  4  match offset
cw_len  in  3  match length
cw_char  in  8  next literal; 8'h24 = terminator
dec_code_pos  out  4  to decoder code_pos
dec_code_len  out  3  to decoder code_len
dec_chardata  out  8  to decoder chardata
dec_encode  in  1  decoder mode; must be 0 while decoding
dec_finish  in  1  decoder finished
dec_char_nxt  in  8  decoder output char
out_valid  out  1  out_char valid this cycle
out_char  out  8  decoded char
out_last  out  1  with out_valid: final char of stream
busy  out  1  state ≠ IDLE/DONE
done  out  1  sticky; set in DONE
err_timeout  out  1  sticky watchdog error
cw_count  out  16  code words issued, saturating

Behaviour:
- Reset values (async, reset==0): all outputs 0, FIFO empty, cw_count 0, state IDLE. Reset mid-operation aborts immediately; partial stream is discarded.
- FIFO:
  - Push when cw_valid && cw_ready.
  - Pop only by the FSM.
  - Simultaneous push and pop when full is not allowed: cw_ready is 0 when full, regardless of pop.
  - Pointers wrap modulo FIFO_DEPTH; the count register is one bit wider.
- FSM states: IDLE, ISSUE, WAIT_FIN, DONE, ERR.
  - IDLE: if FIFO not empty, pop into hold register, drive dec_* from it (registered, stable from the next cycle), load cnt = len, cw_count++, go to ISSUE.
  - ISSUE: the code word is held. A capture pipeline flag set one cycle after each ISSUE cycle samples dec_char_nxt into out_char with out_valid=1. Output latency is 2 cycles from ISSUE entry to first out_valid.
    - Non-terminator word: ISSUE lasts len+1 cycles and emits len+1 chars, the last being cw_char.
    - Terminator word (char==8'h24): ISSUE lasts len cycles, emits len chars, and the last one carries out_last.
    - pos=0, len=0, $: no ISSUE cycles. Go straight to WAIT_FIN and assert a single out_last pulse with out_valid=0.
    - Back-to-back: at the last ISSUE cycle, if the FIFO is not empty, pop the next word directly, with no IDLE bubble.
  - Stall in ISSUE: while dec_encode==1, cnt holds and no capture occurs.
  - WAIT_FIN: when dec_finish==1, go to DONE. Words pushed after the terminator remain in the FIFO unissued.
  - DONE: done=1, dec_* held. Exit only by reset.
  - Watchdog: counts consecutive cycles with dec_encode==1 in ISSUE, or dec_finish==0 in WAIT_FIN. When the count reaches TIMEOUT, go to ERR: err_timeout=1, dec_* zeroed, outputs quiet until reset.
  - dec_finish asserting during ISSUE: go to ERR immediately.
- cw_count saturates at 16'hFFFF.

Decomposition:
- Package lz77_pkg:
  - LZ_TERM = 8'h24
  - POS_W = 4, LEN_W = 3, CHAR_W = 8
  - typedef struct packed codeword_t {pos, len, chr}
  - typedef enum seq_state_t
- One sub-module: lz77_cw_fifo (parameterised depth, codeword_t data, push/pop/full/empty).
- The FSM, counters and watchdog stay in lz77_dec_sequencer.

Test Plan:
- Single word (pos 2, len 3, char 8'h05), decoder model returning A,B,C,5 → four out_valid pulses in order; first pulse 2 cycles after ISSUE entry; cw_count=1.
- Three words pushed back-to-back, len 0,2,1 → 1+3+2=6 chars, no bubble cycles between words; cw_ready never drops (depth 4).
- Terminator (pos 1, len 2, $) → 2 chars, second with out_last=1; dec_finish asserted 3 cycles later → done=1, busy=0.
- Terminator (0,0,$) after one normal word → no extra out_valid; out_last pulse alone; WAIT_FIN → DONE on dec_finish.
- FIFO full: push 6 words with the FSM stalled by dec_encode=1 → cw_ready=0 after 4 stored; release → all words eventually issued in order.
- Watchdog: hold dec_encode=1 for 16 cycles in ISSUE → err_timeout=1, dec_* = 0. Assert reset mid-ISSUE → all outputs 0 on the same edge.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 decoder sequencer.
//   LZ_TERM         : literal that marks the end of a stream ('$')
//   POS_W/LEN_W/... : field widths of one LZ77 code word
//   codeword_t      : {pos, len, chr} as buffered and issued to the decoder
//   seq_state_t     : sequencer FSM states
package lz77_pkg;

    localparam int POS_W  = 4;
    localparam int LEN_W  = 3;
    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] LZ_TERM = 8'h24;

    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [LEN_W-1:0]  len;
        logic [CHAR_W-1:0] chr;
    } codeword_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_FIN,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/lz77_cw_fifo.sv
// Code-word buffer between the upstream stream and the sequencer FSM.
//   clk, reset : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   pop        : advance read pointer (ignored when empty)
//   pop_data   : head entry (show-ahead, valid while !empty)
//   full/empty : occupancy flags
// Pointers wrap modulo DEPTH; the occupancy counter is one bit wider so
// full and empty are distinguishable.
module lz77_cw_fifo
    import lz77_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  codeword_t push_data,
    input  logic      pop,
    output codeword_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    codeword_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lz77_dec_sequencer.sv
// Sequencer for the LZ77_Decoder datapath.
//   cw_*          : upstream code-word stream (valid/ready), buffered in a FIFO
//   dec_*  (out)  : code word held stable for the decoder
//   dec_encode    : decoder mode; 1 stalls issuing
//   dec_finish    : decoder finished (expected only after the terminator)
//   dec_char_nxt  : decoder output char, captured one cycle after each issue cycle
//   out_*         : registered decoded-char stream, out_last marks the final char
//   busy/done     : FSM activity / sticky completion
//   err_timeout   : sticky watchdog / protocol error
//   cw_count      : code words issued, saturating
module lz77_dec_sequencer
    import lz77_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [POS_W-1:0]  cw_pos,
    input  logic [LEN_W-1:0]  cw_len,
    input  logic [CHAR_W-1:0] cw_char,
    output logic [POS_W-1:0]  dec_code_pos,
    output logic [LEN_W-1:0]  dec_code_len,
    output logic [CHAR_W-1:0] dec_chardata,
    input  logic              dec_encode,
    input  logic              dec_finish,
    input  logic [CHAR_W-1:0] dec_char_nxt,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [15:0]       cw_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    seq_state_t        state;
    codeword_t         cur;
    codeword_t         head;
    logic [LEN_W-1:0]  cnt;
    logic [WD_W-1:0]   wd;
    logic              cap;
    logic              cap_last;
    logic              zt;
    logic              zt2;
    logic              run;
    logic              full;
    logic              empty;
    logic              pop;
    logic              cur_term;
    logic              head_term;
    logic              head_zero_term;
    logic              last_issue;
    logic              stall_hit;
    logic              to_err;

    lz77_cw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cw_valid && cw_ready),
        .push_data ({cw_pos, cw_len, cw_char}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // run keeps cw_ready low while reset is asserted
    assign cw_ready = run && !full;
    assign {dec_code_pos, dec_code_len, dec_chardata} = cur;

    assign cur_term       = (cur.chr == LZ_TERM);
    assign head_term      = (head.chr == LZ_TERM);
    assign head_zero_term = head_term && (head.len == '0);
    assign last_issue     = (state == S_ISSUE) && !dec_finish && !dec_encode && (cnt == '0);
    assign pop            = !empty && ((state == S_IDLE) || (last_issue && !cur_term));
    assign stall_hit      = (wd == WD_W'(TIMEOUT - 1));
    assign to_err         = ((state == S_ISSUE) && (dec_finish || (dec_encode && stall_hit)))
                         || ((state == S_WAIT_FIN) && !dec_finish && stall_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cur         <= '0;
            cnt         <= '0;
            wd          <= '0;
            cap         <= 1'b0;
            cap_last    <= 1'b0;
            zt          <= 1'b0;
            zt2         <= 1'b0;
            run         <= 1'b0;
            out_valid   <= 1'b0;
            out_char    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            cw_count    <= '0;
        end else begin
            run      <= 1'b1;
            cap      <= 1'b0;
            cap_last <= 1'b0;
            zt       <= 1'b0;
            // A zero-length terminator's out_last goes through two stages so it
            // lands after the previous word's final char, never on top of it.
            zt2       <= zt;
            out_valid <= cap;
            out_last  <= (cap && cap_last) || zt2;
            if (cap) out_char <= dec_char_nxt;

            case (state)
                S_ISSUE: begin
                    if (dec_encode) begin
                        wd <= wd + WD_W'(1);
                    end else begin
                        wd       <= '0;
                        cap      <= 1'b1;
                        cap_last <= cur_term && (cnt == '0);
                        if (cnt != '0) begin
                            cnt <= cnt - LEN_W'(1);
                        end else if (cur_term) begin
                            state <= S_WAIT_FIN;
                        end else if (empty) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_WAIT_FIN: begin
                    if (dec_finish) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: ;
            endcase

            // Terminator words issue len cycles, others len+1, so the count is
            // preloaded one lower for terminators.
            if (pop) begin
                cur   <= head;
                cnt   <= head_term ? head.len - LEN_W'(1) : head.len;
                wd    <= '0;
                zt    <= head_zero_term;
                busy  <= 1'b1;
                state <= head_zero_term ? S_WAIT_FIN : S_ISSUE;
                if (cw_count != '1) cw_count <= cw_count + 16'd1;
            end

            if (to_err) begin
                state       <= S_ERR;
                err_timeout <= 1'b1;
                cur         <= '0;
                cap         <= 1'b0;
                zt2         <= 1'b0;
                out_valid   <= 1'b0;
                out_last    <= 1'b0;
                out_char    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lz77_dec_sequencer.sv
module tb_lz77_dec_sequencer;
    import lz77_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic [3:0]  cw_pos = '0;
    logic [2:0]  cw_len = '0;
    logic [7:0]  cw_char = '0;
    logic [3:0]  dec_code_pos;
    logic [2:0]  dec_code_len;
    logic [7:0]  dec_chardata;
    logic        dec_encode = 1'b0;
    logic        dec_finish = 1'b0;
    logic [7:0]  dec_char_nxt = '0;
    logic        out_valid;
    logic [7:0]  out_char;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] cw_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lz77_dec_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cw_valid     (cw_valid),
        .cw_ready     (cw_ready),
        .cw_pos       (cw_pos),
        .cw_len       (cw_len),
        .cw_char      (cw_char),
        .dec_code_pos (dec_code_pos),
        .dec_code_len (dec_code_len),
        .dec_chardata (dec_chardata),
        .dec_encode   (dec_encode),
        .dec_finish   (dec_finish),
        .dec_char_nxt (dec_char_nxt),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .cw_count     (cw_count)
    );

    task automatic do_reset();
        reset = 1'b0;
        cw_valid = 1'b0; cw_pos = '0; cw_len = '0; cw_char = '0;
        dec_encode = 1'b0; dec_finish = 1'b0; dec_char_nxt = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Drives one word at the current negedge; returns at the next negedge.
    task automatic push1(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        cw_valid = 1'b1; cw_pos = p; cw_len = l; cw_char = c;
        @(negedge clk);
        cw_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cw_ready, out_valid, out_last, busy, done, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {cw_ready, out_valid, out_last, busy, done, err_timeout});
        end
        checks++;
        if ({dec_code_pos, dec_code_len, dec_chardata, out_char, cw_count} !== 39'b0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {dec_code_pos, dec_code_len, dec_chardata, out_char, cw_count});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cw_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", cw_ready, busy);
        end
    endtask

    // Word (2,3,05); decoder returns A,B,C,5 -> four chars starting 2 cycles after ISSUE entry.
    task automatic test_single();
        logic [7:0] seq [4];
        seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43; seq[3] = 8'h05;
        do_reset();
        push1(4'd2, 3'd3, 8'h05);
        @(negedge clk);
        checks++;
        if ({dec_code_pos, dec_code_len, dec_chardata} !== {4'd2, 3'd3, 8'h05} || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got pos=%0d len=%0d chr=%h busy=%b want 2 3 05 1",
                     dec_code_pos, dec_code_len, dec_chardata, busy);
        end
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (k >= 4 && k <= 7)) begin
                errors++;
                $display("FAIL single_valid[%0d]: got %b want %b", k, out_valid, (k >= 4 && k <= 7));
            end
            if (k >= 4 && k <= 7) begin
                checks++;
                if (out_char !== seq[k-4] || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL single_char[%0d]: got %h last=%b want %h last=0",
                             k, out_char, out_last, seq[k-4]);
                end
            end
            if (k == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_end: got %b want 0", busy);
                end
            end
            dec_char_nxt = (k <= 6) ? seq[k-3] : 8'h00;
        end
        checks++;
        if (cw_count !== 16'd1) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", cw_count);
        end
    endtask

    // Lens 0,2,1 pushed on consecutive cycles: 6 contiguous chars, no bubbles.
    task automatic test_back_to_back();
        logic [2:0] exp_len;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            if (k >= 2) begin
                checks++;
                if (cw_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1", k, cw_ready);
                end
                checks++;
                if (out_valid !== (k >= 4 && k <= 9)) begin
                    errors++;
                    $display("FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, (k >= 4 && k <= 9));
                end
                if (k >= 4 && k <= 9) begin
                    checks++;
                    if (out_char !== 8'(8'h60 + k - 1)) begin
                        errors++;
                        $display("FAIL b2b_char[%0d]: got %h want %h", k, out_char, 8'(8'h60 + k - 1));
                    end
                end
                if (k <= 7) begin
                    exp_len = (k == 2) ? 3'd0 : (k <= 5) ? 3'd2 : 3'd1;
                    checks++;
                    if (dec_code_len !== exp_len) begin
                        errors++;
                        $display("FAIL b2b_len[%0d]: got %0d want %0d", k, dec_code_len, exp_len);
                    end
                end
            end
            dec_char_nxt = 8'(8'h60 + k);
            case (k)
                0: begin cw_valid = 1'b1; cw_pos = 4'd1; cw_len = 3'd0; cw_char = 8'h11; end
                1: begin cw_valid = 1'b1; cw_pos = 4'd2; cw_len = 3'd2; cw_char = 8'h22; end
                2: begin cw_valid = 1'b1; cw_pos = 4'd3; cw_len = 3'd1; cw_char = 8'h33; end
                default: cw_valid = 1'b0;
            endcase
            @(negedge clk);
        end
        checks++;
        if (cw_count !== 16'd3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", cw_count);
        end
    endtask

    // Terminator (1,2,$): 2 chars, second with out_last; a later word stays unissued.
    task automatic test_terminator();
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            if (k >= 3) begin
                checks++;
                if (out_valid !== (k == 4 || k == 5) || out_last !== (k == 5)) begin
                    errors++;
                    $display("FAIL term_vl[%0d]: got v=%b l=%b want v=%b l=%b",
                             k, out_valid, out_last, (k == 4 || k == 5), (k == 5));
                end
                if (k == 4 || k == 5) begin
                    checks++;
                    if (out_char !== 8'(8'h50 + k - 1)) begin
                        errors++;
                        $display("FAIL term_char[%0d]: got %h want %h", k, out_char, 8'(8'h50 + k - 1));
                    end
                end
            end
            if (k == 6) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL term_waitfin: got busy=%b done=%b want 1 0", busy, done);
                end
            end
            if (k >= 7) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || dec_chardata !== LZ_TERM || cw_count !== 16'd1) begin
                    errors++;
                    $display("FAIL term_done[%0d]: got done=%b busy=%b chr=%h cnt=%0d want 1 0 24 1",
                             k, done, busy, dec_chardata, cw_count);
                end
            end
            dec_char_nxt = 8'(8'h50 + k);
            dec_finish = (k >= 6);
            case (k)
                0: begin cw_valid = 1'b1; cw_pos = 4'd1; cw_len = 3'd2; cw_char = LZ_TERM; end
                3: begin cw_valid = 1'b1; cw_pos = 4'd3; cw_len = 3'd1; cw_char = 8'h77; end
                default: cw_valid = 1'b0;
            endcase
            @(negedge clk);
        end
        dec_finish = 1'b0;
    endtask

    // Normal (2,1,A) then (0,0,$): two chars, then a lone out_last pulse.
    task automatic test_zero_term();
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            if (k >= 2) begin
                checks++;
                if (out_valid !== (k == 4 || k == 5) || out_last !== (k == 6)) begin
                    errors++;
                    $display("FAIL zterm_vl[%0d]: got v=%b l=%b want v=%b l=%b",
                             k, out_valid, out_last, (k == 4 || k == 5), (k == 6));
                end
            end
            if (k == 7) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL zterm_waitfin: got busy=%b done=%b want 1 0", busy, done);
                end
            end
            if (k >= 8) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || cw_count !== 16'd2) begin
                    errors++;
                    $display("FAIL zterm_done[%0d]: got done=%b busy=%b cnt=%0d want 1 0 2",
                             k, done, busy, cw_count);
                end
            end
            dec_finish = (k >= 7);
            case (k)
                0: begin cw_valid = 1'b1; cw_pos = 4'd2; cw_len = 3'd1; cw_char = 8'h41; end
                1: begin cw_valid = 1'b1; cw_pos = 4'd0; cw_len = 3'd0; cw_char = LZ_TERM; end
                default: cw_valid = 1'b0;
            endcase
            @(negedge clk);
        end
        dec_finish = 1'b0;
    endtask

    // Six len-0 words while the decoder stalls: FIFO fills after 4, all issued in order.
    // Decoder model: one-cycle-late echo of dec_chardata.
    task automatic test_fifo_full();
        logic [7:0] got [6];
        int         n_got;
        int         idx;
        logic       acc;
        logic [7:0] prev_cd;
        n_got = 0; idx = 0; prev_cd = '0;
        do_reset();
        dec_encode = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 4 || k == 5 || k == 6) begin
                checks++;
                if (cw_ready !== (k == 4)) begin
                    errors++;
                    $display("FAIL full_ready[%0d]: got %b want %b", k, cw_ready, (k == 4));
                end
            end
            if (out_valid === 1'b1) begin
                if (n_got < 6) got[n_got] = out_char;
                n_got++;
            end
            dec_char_nxt = prev_cd;
            prev_cd = dec_chardata;
            if (k == 7) dec_encode = 1'b0;
            cw_valid = (idx < 6);
            cw_pos = 4'(idx); cw_len = 3'd0; cw_char = 8'(8'hA0 + idx);
            acc = cw_valid && cw_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        cw_valid = 1'b0;
        checks++;
        if (n_got !== 6 || cw_count !== 16'd6) begin
            errors++;
            $display("FAIL full_total: got chars=%0d cnt=%0d want 6 6", n_got, cw_count);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < n_got) begin
                checks++;
                if (got[i] !== 8'(8'hA0 + i)) begin
                    errors++;
                    $display("FAIL full_order[%0d]: got %h want %h", i, got[i], 8'(8'hA0 + i));
                end
            end
        end
    endtask

    // 16 stalled ISSUE cycles -> ERR with dec_* zeroed.
    task automatic test_watchdog();
        do_reset();
        dec_encode = 1'b1;
        push1(4'd1, 3'd3, 8'h7A);
        for (int k = 2; k <= 21; k++) begin
            @(negedge clk);
            if (k == 17) begin
                checks++;
                if (err_timeout !== 1'b0 || dec_code_len !== 3'd3) begin
                    errors++;
                    $display("FAIL wd_early: got err=%b len=%0d want 0 3", err_timeout, dec_code_len);
                end
            end
            if (k >= 18) begin
                checks++;
                if (err_timeout !== 1'b1 || {dec_code_pos, dec_code_len, dec_chardata} !== 15'b0
                    || out_valid !== 1'b0 || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_err[%0d]: got err=%b dec=%h v=%b l=%b want 1 0 0 0", k, err_timeout,
                             {dec_code_pos, dec_code_len, dec_chardata}, out_valid, out_last);
                end
            end
            if (k == 19) dec_encode = 1'b0;
        end
    endtask

    // dec_finish while issuing is a protocol error.
    task automatic test_finish_in_issue();
        do_reset();
        push1(4'd0, 3'd3, 8'h51);
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fin_pre: got err=%b busy=%b want 0 1", err_timeout, busy);
        end
        dec_finish = 1'b1;
        @(negedge clk);
        dec_finish = 1'b0;
        checks++;
        if (err_timeout !== 1'b1 || dec_code_len !== 3'd0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL fin_err: got err=%b len=%0d v=%b done=%b want 1 0 0 0",
                     err_timeout, dec_code_len, out_valid, done);
        end
    endtask

    // Reset mid-ISSUE clears everything asynchronously; the partial stream is gone.
    task automatic test_reset_mid();
        do_reset();
        dec_char_nxt = 8'h99;
        push1(4'd0, 3'd7, 8'h6D);
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_active: got v=%b busy=%b want 1 1", out_valid, busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cw_ready, out_valid, out_last, busy, done, err_timeout} !== 6'b0
            || {dec_code_pos, dec_code_len, dec_chardata, out_char, cw_count} !== 39'b0) begin
            errors++;
            $display("FAIL rmid_clear: got flags=%b data=%h want 0 0",
                     {cw_ready, out_valid, out_last, busy, done, err_timeout},
                     {dec_code_pos, dec_code_len, dec_chardata, out_char, cw_count});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cw_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || cw_count !== 16'd0) begin
            errors++;
            $display("FAIL rmid_after: got ready=%b busy=%b v=%b cnt=%0d want 1 0 0 0",
                     cw_ready, busy, out_valid, cw_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_terminator();
        test_zero_term();
        test_fifo_full();
        test_watchdog();
        test_finish_in_issue();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
